countdown_reload_top: RTL and testbench



---
 rtl/countdown_pkg.sv | 9 +
 rtl/countdown_reload_if.sv | 22 ++
 rtl/countdown_reload_top.sv | 88 ++++++++
 tb/tb_countdown_reload_top.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types for the loadable countdown timer.
package countdown_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } countdown_state_e;

endpackage

// File: rtl/countdown_reload_if.sv
// Load handshake between a requester (master) and the countdown timer (slave).
interface countdown_reload_if #(
  parameter int WIDTH = 4
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;

  modport master (
    output load_valid,
    output load_value,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    output load_ready
  );

endinterface

// File: rtl/countdown_reload_top.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
//
// state | meaning
// IDLE  | waiting for a load; load_ready high, count holds
// RUN   | counting down on enable; busy high
module countdown_reload_top
  import countdown_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  countdown_reload_if.slave load_bus,
  input  logic             auto_reload,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire
);

  countdown_state_e state, state_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             expire_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      expire     <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      expire     <= expire_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    expire_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (load_bus.load_valid) begin
          if (load_bus.load_value != '0) begin
            count_nxt  = load_bus.load_value;
            reload_nxt = load_bus.load_value;
            state_nxt  = RUN;
          end else begin
            // zero-length timer expires without ever entering RUN
            expire_nxt = 1'b1;
            count_nxt  = '0;
          end
        end
      end
      RUN: begin
        if (abort) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (enable) begin
          if (count > WIDTH'(1)) begin
            count_nxt = count - WIDTH'(1);
          end else begin
            // count is never 0 in RUN, so this is the terminal cycle
            expire_nxt = 1'b1;
            if (auto_reload) begin
              count_nxt = reload_reg;
            end else begin
              count_nxt = '0;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy                = (state == RUN);
    load_bus.load_ready = (state == IDLE);
  end

endmodule

// File: tb/tb_countdown_reload_top.sv
// Self-checking bench for countdown_reload_top: vector table plus scoreboard.
module tb_countdown_reload_top;

  localparam int WIDTH = 4;

  typedef struct {
    logic             lv;
    logic [WIDTH-1:0] val;
    logic             ar;
    logic             en;
    logic             ab;
    logic [WIDTH-1:0] e_cnt;
    logic             e_busy;
    logic             e_rdy;
    logic             e_exp;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             rdy;
    logic             exp;
  } exp_t;

  logic             clk;
  logic             reset_n;
  logic             auto_reload;
  logic             enable;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expire;

  int tests  = 0;
  int failed = 0;

  vec_t vecs[$];
  exp_t sb[$];

  countdown_reload_if #(.WIDTH(WIDTH)) lb ();

  countdown_reload_top #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_bus    (lb),
    .auto_reload (auto_reload),
    .enable      (enable),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .expire      (expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic lv, input int val, input logic ar, input logic en,
                     input logic ab, input int e_cnt, input logic e_busy,
                     input logic e_rdy, input logic e_exp);
    vec_t v;
    v.lv = lv; v.val = WIDTH'(val); v.ar = ar; v.en = en; v.ab = ab;
    v.e_cnt = WIDTH'(e_cnt); v.e_busy = e_busy; v.e_rdy = e_rdy; v.e_exp = e_exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] c, input logic b,
                       input logic r, input logic e, input exp_t x);
    tests++;
    if (c !== x.cnt || b !== x.busy || r !== x.rdy || e !== x.exp) begin
      failed++;
      $display("FAIL %s: got cnt=%0d busy=%b rdy=%b exp=%b, want cnt=%0d busy=%b rdy=%b exp=%b",
               name, c, b, r, e, x.cnt, x.busy, x.rdy, x.exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, then compare after the edge.
  task automatic step(input string name, input logic lv, input logic [WIDTH-1:0] val,
                      input logic ar, input logic en, input logic ab,
                      input logic [WIDTH-1:0] e_cnt, input logic e_busy,
                      input logic e_rdy, input logic e_exp);
    exp_t x;
    lb.load_valid = lv; lb.load_value = val;
    auto_reload = ar; enable = en; abort = ab;
    x.cnt = e_cnt; x.busy = e_busy; x.rdy = e_rdy; x.exp = e_exp;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check(name, count, busy, lb.load_ready, expire, x);
    @(negedge clk);
  endtask

  initial begin
    exp_t idle0;
    idle0.cnt = '0; idle0.busy = 1'b0; idle0.rdy = 1'b1; idle0.exp = 1'b0;

    lb.load_valid = 1'b0; lb.load_value = '0;
    auto_reload = 1'b0; enable = 1'b0; abort = 1'b0;
    reset_n = 1'b0;
    #12;
    check("reset", count, busy, lb.load_ready, expire, idle0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    //  lv val ar en ab   cnt busy rdy exp
    // load 3, no reload
    add(1, 3, 0, 1, 0,   3, 1, 0, 0);
    add(0, 0, 0, 1, 0,   2, 1, 0, 0);
    add(0, 0, 0, 1, 0,   1, 1, 0, 0);
    add(0, 0, 0, 1, 0,   0, 0, 1, 1);
    // back-to-back load 2 with auto-reload
    add(1, 2, 1, 1, 0,   2, 1, 0, 0);
    add(0, 0, 1, 1, 0,   1, 1, 0, 0);
    add(0, 0, 1, 1, 0,   2, 1, 0, 1);
    add(0, 0, 1, 1, 0,   1, 1, 0, 0);
    add(0, 0, 1, 1, 0,   2, 1, 0, 1);
    add(0, 0, 1, 1, 0,   1, 1, 0, 0);
    add(0, 0, 0, 1, 0,   0, 0, 1, 1);
    add(0, 0, 0, 1, 0,   0, 0, 1, 0);
    // load 4 with enable 1,0,0,1,1,1
    add(1, 4, 0, 0, 0,   4, 1, 0, 0);
    add(0, 0, 0, 1, 0,   3, 1, 0, 0);
    add(0, 0, 0, 0, 0,   3, 1, 0, 0);
    add(0, 0, 0, 0, 0,   3, 1, 0, 0);
    add(0, 0, 0, 1, 0,   2, 1, 0, 0);
    add(0, 0, 0, 1, 0,   1, 1, 0, 0);
    add(0, 0, 0, 1, 0,   0, 0, 1, 1);
    add(0, 0, 0, 0, 0,   0, 0, 1, 0);
    // load 6, pending load of 9 held, abort at count 1
    add(1, 6, 0, 1, 0,   6, 1, 0, 0);
    add(1, 9, 0, 1, 0,   5, 1, 0, 0);
    add(1, 9, 0, 1, 0,   4, 1, 0, 0);
    add(1, 9, 0, 1, 0,   3, 1, 0, 0);
    add(1, 9, 0, 1, 0,   2, 1, 0, 0);
    add(1, 9, 0, 1, 0,   1, 1, 0, 0);
    add(1, 9, 1, 1, 1,   0, 0, 1, 0);
    add(1, 9, 0, 0, 0,   9, 1, 0, 0);
    add(0, 0, 0, 1, 1,   0, 0, 1, 0);
    // zero loads back to back, then abort/enable ignored in IDLE
    add(1, 0, 0, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0, 0, 0,   0, 0, 1, 1);
    add(0, 0, 1, 1, 1,   0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].lv, vecs[i].val, vecs[i].ar, vecs[i].en,
           vecs[i].ab, vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_rdy, vecs[i].e_exp);
    end

    // full-scale load: 15 enabled edges to expire, no wrap
    begin
      int edges;
      bit seen;
      step("load15", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
      edges = 0;
      seen  = 1'b0;
      lb.load_valid = 1'b0; enable = 1'b1;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(posedge clk);
        #1;
        edges++;
        if (expire) seen = 1'b1;
        else if (count !== WIDTH'(15 - edges)) begin
          tests++; failed++;
          $display("FAIL cnt15_e%0d: got %0d want %0d", edges, count, 15 - edges);
        end
      end
      tests++;
      if (!seen || edges != 15 || count !== '0 || busy !== 1'b0) begin
        failed++;
        $display("FAIL expire15: got seen=%b edges=%0d cnt=%0d busy=%b, want seen=1 edges=15 cnt=0 busy=0",
                 seen, edges, count, busy);
      end
      @(negedge clk);
    end

    // asynchronous reset mid-run at count 5
    step("load7", 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
    step("dec6",  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
    step("dec5",  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", count, busy, lb.load_ready, expire, idle0);
    @(negedge clk);
    reset_n = 1'b1;
    step("post_rst", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step("reload_cleared", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    step("reload1", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
